// File: rtl/apb_master_pkg.sv
// Shared types for the APB command master: FSM state encoding and the latched command record.
package apb_master_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_t;

    typedef struct packed {
        logic                    write;
        logic [APB_ADDR_W-1:0]   addr;
        logic [APB_DATA_W-1:0]   wdata;
        logic [APB_DATA_W/8-1:0] strb;
    } apb_cmd_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating count of PREADY-low ACCESS cycles; flags the cycle on which the limit is reached.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned       CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign o_expired = 1'b0;
        end else begin : g_timeout
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_W'(1);
            // Fires during the TIMEOUT-th low cycle so the count lands on TIMEOUT as ACCESS exits.
            assign o_expired = i_enable && (r_cnt == CNT_LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_cmd_master.sv
// APB requester: one valid/ready command becomes one SETUP/ACCESS transfer and one response.
import apb_master_pkg::*;

module apb_cmd_master #(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY
);

    generate
        if (ADDR_W != APB_ADDR_W || DATA_W != APB_DATA_W) begin : g_width_check
            $error("apb_cmd_master: ADDR_W/DATA_W must match apb_master_pkg widths");
        end
    endgenerate

    apb_mst_state_t    r_state;
    apb_mst_state_t    w_state_next;
    apb_cmd_t          r_cmd;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rst_done;
    logic              w_cmd_hs;
    logic              w_expired;
    logic              w_timer_clear;
    logic              w_timer_en;

    assign w_cmd_hs      = req_valid && req_ready;
    assign w_timer_clear = (r_state == SETUP);
    assign w_timer_en    = (r_state == ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .i_clk     (PCLK),
        .i_rst     (PRESET),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        PSEL         = 1'b0;
        PENABLE      = 1'b0;
        rsp_valid    = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Held low until the first edge after reset release.
                req_ready = r_rst_done;
                if (w_cmd_hs) begin
                    w_state_next = SETUP;
                end
            end
            SETUP: begin
                PSEL         = 1'b1;
                w_state_next = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || w_expired) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state    <= IDLE;
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rst_done <= 1'b1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_cmd <= '0;
        end else if (w_cmd_hs) begin
            r_cmd.write <= req_write;
            r_cmd.addr  <= req_addr;
            r_cmd.wdata <= req_wdata;
            r_cmd.strb  <= req_strb;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (r_state == ACCESS) begin
            if (PREADY) begin
                r_rsp_rdata <= r_cmd.write ? '0 : PRDATA;
                r_rsp_err   <= 1'b0;
            end else if (w_expired) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    // APB address/data come straight from the command register, so they hold after ACCESS.
    assign PWRITE    = r_cmd.write;
    assign PADDR     = r_cmd.addr;
    assign PWDATA    = r_cmd.wdata;
    assign PSTRB     = r_cmd.strb;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Table-driven bench for apb_cmd_master against a byte-addressed APB stub slave with wait control.
module tb_apb_cmd_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_cmd_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    // Stub slave: 16-byte memory, lane i maps to byte PADDR+i; word-crossing costs one extra wait.
    logic [7:0]  mem [16] = '{default: 8'h00};
    int unsigned cfg_wait = 0;
    int unsigned wcnt = 0;
    bit          stall = 1'b0;
    logic        w_cross;

    always_comb begin
        w_cross = 1'b0;
        PRDATA  = '0;
        for (int i = 0; i < 4; i++) begin
            if (PSTRB[i] && (int'(PADDR[1:0]) + i > 3)) w_cross = 1'b1;
            if (PSTRB[i]) PRDATA[8*i +: 8] = mem[4'(PADDR[3:0] + 4'(i))];
        end
        PREADY = PSEL && PENABLE && !stall && (wcnt >= cfg_wait + (w_cross ? 1 : 0));
    end

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) begin
            for (int i = 0; i < 4; i++) begin
                if (PSTRB[i]) mem[4'(PADDR[3:0] + 4'(i))] <= PWDATA[8*i +: 8];
            end
        end
    end

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int unsigned waits;
        bit          stall;
        int unsigned hold;
        int unsigned exp_acc;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        int acc;
        chk($sformatf("v%0d idle_psel", idx), {PSEL, PENABLE}, 2'b00);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_strb  = v.strb;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge PCLK); #1;
            n++;
        end
        chk($sformatf("v%0d req_ready", idx), req_ready, 1'b1);
        stall    = v.stall;
        cfg_wait = v.waits;
        @(posedge PCLK); #1;
        // Scramble the request inputs to show the command was latched.
        req_valid = 1'b0;
        req_addr  = '1;
        req_wdata = '1;
        req_strb  = '0;
        req_write = ~v.write;
        chk($sformatf("v%0d setup_sel_en", idx), {PSEL, PENABLE, req_ready}, 3'b100);
        chk($sformatf("v%0d setup_bus", idx), {PWRITE, PADDR, PWDATA, PSTRB},
            {v.write, v.addr, v.wdata, v.strb});
        @(posedge PCLK); #1;
        acc = 0;
        while (PSEL && PENABLE && acc < 40) begin
            acc++;
            chk($sformatf("v%0d access_bus", idx), {PWRITE, PADDR, PWDATA, PSTRB, req_ready},
                {v.write, v.addr, v.wdata, v.strb, 1'b0});
            @(posedge PCLK); #1;
        end
        chk($sformatf("v%0d access_cycles", idx), acc, v.exp_acc);
        chk($sformatf("v%0d resp_apb_idle", idx), {PSEL, PENABLE, req_ready}, 3'b000);
        chk($sformatf("v%0d resp", idx), {rsp_valid, rsp_err, rsp_rdata},
            {1'b1, v.exp_err, v.exp_rdata});
        req_valid = (v.hold > 0);
        for (int i = 0; i < int'(v.hold); i++) begin
            @(posedge PCLK); #1;
            chk($sformatf("v%0d hold", idx), {rsp_valid, rsp_err, rsp_rdata, req_ready, PSEL},
                {1'b1, v.exp_err, v.exp_rdata, 1'b0, 1'b0});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
        stall     = 1'b0;
        chk($sformatf("v%0d resp_done", idx), {rsp_valid, req_ready, PSEL}, 3'b010);
    endtask

    initial begin
        //        wr    addr   wdata         strb  wt stl hld acc rdata         err
        vecs[0]  = '{1'b1, 32'h4, 32'h0000_0003, 4'hF, 1, 0, 0, 2, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 32'h0, 32'h0002_0005, 4'hF, 0, 0, 0, 1, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 32'h0, 32'h0000_0000, 4'hF, 0, 0, 0, 1, 32'h0002_0005, 1'b0};
        vecs[3]  = '{1'b1, 32'h1, 32'hAABB_CCDD, 4'hF, 0, 0, 0, 2, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0, 32'h0000_0000, 4'hF, 2, 0, 0, 3, 32'hBBCC_DD05, 1'b0};
        vecs[5]  = '{1'b0, 32'h4, 32'h0000_0000, 4'hF, 0, 0, 0, 1, 32'h0000_00AA, 1'b0};
        vecs[6]  = '{1'b0, 32'h2, 32'h0000_0000, 4'h3, 0, 0, 0, 1, 32'h0000_BBCC, 1'b0};
        vecs[7]  = '{1'b1, 32'h8, 32'h1234_5678, 4'hF, 0, 1, 0, 16, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 32'h8, 32'h0000_0000, 4'hF, 0, 0, 0, 1, 32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b0, 32'h0, 32'h0000_0000, 4'hF, 0, 0, 5, 1, 32'hBBCC_DD05, 1'b0};
        vecs[10] = '{1'b0, 32'h3, 32'h0000_0000, 4'h3, 0, 0, 0, 2, 32'h0000_AABB, 1'b0};

        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        rsp_ready = 1'b0;
        #1;
        chk("reset_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB},
            {3'b000, 32'h0, 32'h0, 4'h0});
        chk("reset_handshake", {req_ready, rsp_valid, rsp_err, rsp_rdata}, {3'b000, 32'h0});
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(posedge PCLK); #1;
        chk("post_reset_ready", req_ready, 1'b1);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Reset asserted mid-ACCESS on a stalled write.
        stall     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'hC;
        req_wdata = 32'hDEAD_BEEF;
        req_strb  = 4'hF;
        @(posedge PCLK); #1;
        req_valid = 1'b0;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        chk("pre_reset_access", {PSEL, PENABLE}, 2'b11);
        #2 PRESET = 1'b1;
        #1;
        chk("async_reset_apb", {PSEL, PENABLE, PWRITE, PADDR, PSTRB}, {3'b000, 32'h0, 4'h0});
        chk("async_reset_rsp", {rsp_valid, req_ready}, 2'b00);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        stall  = 1'b0;
        @(posedge PCLK); #1;
        chk("reset_release_ready", {req_ready, PSEL, rsp_valid}, 3'b100);
        chk("aborted_write_dropped", {mem[12], mem[13], mem[14], mem[15]}, 32'h0);

        run_vec(11, vecs[5]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
